// File: rtl/pixel_frame_capture_if.sv
// Pixel-stream and readout handshake bundle for pixel_frame_capture.
// The master side feeds strobed pixels and accepts buffered readout; the slave is the capture block.
interface pixel_frame_capture_if #(
  parameter int counter_width = 8
);
  logic                     read;
  logic [counter_width-1:0] pixel_in;
  logic                     frame_start;
  logic [counter_width-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     frame_done;
  logic                     overflow;

  modport master (
    output read, pixel_in, frame_start, out_ready,
    input  out_data, out_valid, out_last, frame_done, overflow
  );

  modport slave (
    input  read, pixel_in, frame_start, out_ready,
    output out_data, out_valid, out_last, frame_done, overflow
  );
endinterface

// File: rtl/pixel_frame_capture.sv
// Captures one raster-ordered frame of strobed pixels, then streams it out with a
// valid/ready handshake; strobes arriving while the frame is being read out are dropped.
module pixel_frame_capture #(
  parameter int array_width   = 10,
  parameter int array_height  = 10,
  parameter int counter_width = 8
) (
  input  logic                 system_clk,
  input  logic                 reset,
  pixel_frame_capture_if.slave bus
);

  localparam int pixel_count = array_width * array_height;
  localparam int idx_width   = $clog2(pixel_count);
  localparam logic [idx_width-1:0] last_idx = idx_width'(pixel_count - 1);

  typedef enum logic {
    CAPTURE = 1'b0,
    READOUT = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [idx_width-1:0]     wr_idx_q, wr_idx_d;
  logic [idx_width-1:0]     rd_idx_q, rd_idx_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overflow_q, overflow_d;
  logic                     wr_en;
  logic [idx_width-1:0]     wr_addr;
  logic [counter_width-1:0] buffer_q [pixel_count];

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state_q      <= CAPTURE;
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Frame storage keeps its contents across reset; only a strobe outside reset writes it.
  always_ff @(posedge system_clk) begin
    if (wr_en && !reset) begin
      buffer_q[wr_addr] <= bus.pixel_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    wr_en        = 1'b0;
    // A resync strobe lands at index 0 in the same cycle it is requested.
    wr_addr      = bus.frame_start ? '0 : wr_idx_q;

    case (state_q)
      CAPTURE: begin
        if (bus.read) begin
          wr_en = 1'b1;
          if (wr_addr == last_idx) begin
            state_d      = READOUT;
            wr_idx_d     = '0;
            rd_idx_d     = '0;
            frame_done_d = 1'b1;
          end else begin
            wr_idx_d = wr_addr + 1'b1;
          end
        end else if (bus.frame_start) begin
          wr_idx_d = '0;
        end
      end

      READOUT: begin
        if (bus.read) begin
          overflow_d = 1'b1;
        end
        if (bus.out_ready) begin
          if (rd_idx_q == last_idx) begin
            state_d  = CAPTURE;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end

      default: state_d = CAPTURE;
    endcase
  end

  assign bus.out_valid  = (state_q == READOUT);
  assign bus.out_data   = buffer_q[rd_idx_q];
  assign bus.out_last   = (state_q == READOUT) && (rd_idx_q == last_idx);
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Self-checking bench: directed frame scenarios plus random traffic, all compared each
// cycle against a frame-level reference model; literal expectations pin the model.
module tb_pixel_frame_capture;
  localparam int AW = 10;
  localparam int AH = 10;
  localparam int CW = 8;
  localparam int PC = AW * AH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_frame_capture_if #(.counter_width(CW)) bus ();

  pixel_frame_capture #(
    .array_width  (AW),
    .array_height (AH),
    .counter_width(CW)
  ) dut (
    .system_clk(clk),
    .reset     (rst),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame being filled, then a frame being drained.
  bit m_cap;
  int m_wr;
  int m_rd;
  bit m_done;
  bit m_ovf;
  int m_frame [PC];

  int xfers[$];
  int last_pos[$];
  int done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rd, input int pix, input bit fs, input bit rdy, input bit r);
    if (r) begin
      m_cap = 1'b1; m_wr = 0; m_rd = 0; m_done = 1'b0; m_ovf = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (m_cap) begin
      if (fs) m_wr = 0;
      if (rd) begin
        m_frame[m_wr] = pix;
        m_wr++;
        if (m_wr == PC) begin
          m_cap = 1'b0; m_wr = 0; m_rd = 0; m_done = 1'b1;
        end
      end
    end else begin
      if (rd) m_ovf = 1'b1;
      if (rdy) begin
        if (m_rd == PC - 1) m_cap = 1'b1;
        else m_rd++;
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(bus.out_valid), 32'(!m_cap));
    chk("out_last", 32'(bus.out_last), 32'(!m_cap && m_rd == PC - 1));
    chk("frame_done", 32'(bus.frame_done), 32'(m_done));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (!m_cap) chk("out_data", 32'(bus.out_data), 32'(m_frame[m_rd] & 255));
  endtask

  task automatic cyc(input bit rd, input int pix, input bit fs, input bit rdy, input bit r);
    bus.read        = rd;
    bus.pixel_in    = CW'(pix);
    bus.frame_start = fs;
    bus.out_ready   = rdy;
    rst             = r;
    if (!r && bus.out_valid === 1'b1 && rdy) begin
      xfers.push_back(int'(bus.out_data));
      if (bus.out_last === 1'b1) last_pos.push_back(xfers.size() - 1);
      $display("xfer #%0d data=%0h last=%0b", xfers.size() - 1, bus.out_data, bus.out_last);
    end
    @(posedge clk);
    model_step(rd, pix & 255, fs, rdy, r);
    @(negedge clk);
    compare();
    if (bus.frame_done === 1'b1) done_cnt++;
  endtask

  task automatic capture_frame(input int base);
    for (int i = 0; i < PC; i++) cyc(1'b1, (base + i) & 255, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: ready held high; mode 1: ready toggles 1-0-1 starting high.
  task automatic drain(input int mode, input bit strobe, input int pix);
    int n;
    n = 0;
    xfers.delete();
    last_pos.delete();
    while (bus.out_valid === 1'b1 && n < 400) begin
      cyc(strobe, pix, 1'b0, (mode == 0) ? 1'b1 : (n % 2 == 0), 1'b0);
      n++;
    end
    chk("drain_bound", 32'(n < 400), 32'd1);
  endtask

  task automatic check_frame(input string name, input int first, input int base);
    chk({name, "_count"}, 32'(xfers.size()), 32'(PC));
    if (xfers.size() == PC) begin
      chk({name, "_px0"}, 32'(xfers[0]), 32'(first & 255));
      for (int i = 1; i < PC; i++) chk({name, "_px"}, 32'(xfers[i]), 32'((base + i) & 255));
    end
    chk({name, "_last_count"}, 32'(last_pos.size()), 32'd1);
    if (last_pos.size() == 1) chk({name, "_last_pos"}, 32'(last_pos[0]), 32'(PC - 1));
  endtask

  initial begin
    m_cap = 1'b1; m_wr = 0; m_rd = 0; m_done = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < PC; i++) m_frame[i] = 0;
    done_cnt = 0;
    bus.read = 1'b0; bus.pixel_in = '0; bus.frame_start = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    repeat (3) cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);

    // Plain frame, ready held high.
    done_cnt = 0;
    for (int i = 0; i < PC - 1; i++) cyc(1'b1, i, 1'b0, 1'b1, 1'b0);
    chk("done_before_last", 32'(bus.frame_done), 32'd0);
    cyc(1'b1, PC - 1, 1'b0, 1'b1, 1'b0);
    chk("done_after_100", 32'(bus.frame_done), 32'd1);
    chk("valid_with_done", 32'(bus.out_valid), 32'd1);
    drain(0, 1'b0, 0);
    check_frame("f1", 0, 0);
    chk("f1_done_pulses", 32'(done_cnt), 32'd1);
    chk("f1_back_to_capture", 32'(bus.out_valid), 32'd0);

    // Same frame, ready toggling.
    capture_frame(0);
    drain(1, 1'b0, 0);
    check_frame("f2", 0, 0);

    // Resync after 37 strobes.
    for (int i = 0; i < 37; i++) cyc(1'b1, i + 1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < PC - 1; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    chk("resync_done_early", 32'(bus.frame_done), 32'd0);
    cyc(1'b1, PC - 1, 1'b0, 1'b0, 1'b0);
    chk("resync_done", 32'(bus.frame_done), 32'd1);
    drain(0, 1'b0, 0);
    check_frame("f3", 8'h55, 0);

    // Strobes throughout readout, including the final transfer cycle.
    capture_frame(10);
    drain(1, 1'b1, 8'hFF);
    check_frame("f4", 10, 10);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    cyc(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < PC; i++) cyc(1'b1, 10 + i, 1'b0, 1'b0, 1'b0);
    drain(0, 1'b0, 0);
    check_frame("f5", 8'hAB, 10);
    chk("ovf_persists", 32'(bus.overflow), 32'd1);

    // Reset in the middle of readout.
    capture_frame(20);
    for (int i = 0; i < 50; i++) cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b1);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_last", 32'(bus.out_last), 32'd0);
    chk("midrst_ovf", 32'(bus.overflow), 32'd0);
    capture_frame(200);
    drain(0, 1'b0, 0);
    check_frame("f6", 200, 200);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      cyc($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)),
          $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6,
          $urandom_range(0, 499) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_frame_capture.md
PIXEL_FRAME_CAPTURE -- requirements
Module: pixel_frame_capture

Interface
REQ-001 SHALL have parameter array_width, default 10, pixel columns per frame.
REQ-002 SHALL have parameter array_height, default 10, pixel rows per frame.
REQ-003 SHALL have parameter counter_width, default 8, bit width of one pixel sample.
REQ-004 SHALL derive local pixel_count = array_width*array_height (>= 2) and idx_width = $clog2(pixel_count).
REQ-005 SHALL have port system_clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port read  input  1  pixel strobe from pixel_top; pixel_in valid this cycle.
REQ-008 SHALL have port pixel_in  input  counter_width  pixel sample from pixel_top pixel_out.
REQ-009 SHALL have port frame_start  input  1  forces write index to 0 (resync).
REQ-010 SHALL have port out_data  output  counter_width  buffered pixel at current read index.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid pixel.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port out_last  output  1  out_data is final pixel of frame.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse: frame fully captured.
REQ-015 SHALL have port overflow  output  1  sticky: a strobe was dropped.

Function
REQ-016 SHALL store pixels in an internal pixel_count x counter_width register array, raster order (index = row*array_width + col).
REQ-017 SHALL implement FSM states CAPTURE and READOUT; reset state CAPTURE.
REQ-018 CAPTURE: read=1 writes pixel_in to buffer[wr_idx], wr_idx+1 at the same edge.
REQ-019 CAPTURE: frame_start=1 sets wr_idx to 0; with read=1 in the same cycle, pixel goes to index 0 and wr_idx becomes 1.
REQ-020 CAPTURE: write at wr_idx = pixel_count-1 moves FSM to READOUT, wr_idx to 0, rd_idx to 0, frame_done=1 for exactly the next cycle.
REQ-021 READOUT: out_valid=1 combinationally on state; out_data = buffer[rd_idx]; out_last = (rd_idx == pixel_count-1).
REQ-022 CAPTURE: out_valid=0, out_last=0; out_data value is don't-care.
REQ-023 Transfer occurs when out_valid && out_ready; rd_idx+1 at that edge; out_data and rd_idx SHALL hold while out_ready=0.
REQ-024 Transfer with out_last=1 returns FSM to CAPTURE next cycle; the first capture write is accepted that next cycle.
REQ-025 READOUT: read=1 SHALL NOT modify the buffer and sets overflow=1, including in the cycle of the final transfer.
REQ-026 READOUT: frame_start is ignored.
REQ-027 overflow SHALL remain 1 until reset.
REQ-028 First frame_done pulse appears one cycle after the 100th strobe (default params); out_valid rises in the same cycle.

Reset
REQ-029 reset=1 at an edge SHALL set state CAPTURE, wr_idx=0, rd_idx=0, frame_done=0, overflow=0, out_valid=0, out_last=0, in any state, including mid-readout.
REQ-030 Buffer contents SHALL NOT be cleared by reset.
REQ-031 read during a reset cycle SHALL be ignored.

Verification
REQ-032 100 consecutive strobes with pixel_in=i (0..99), out_ready=1 -> frame_done pulse once, 100 transfers with out_data 0..99, out_last only on 99, then CAPTURE.
REQ-033 Same frame, out_ready toggled 1-0-1 each cycle -> out_data stable while out_ready=0, no pixel skipped or repeated.
REQ-034 Strobes during READOUT with pixel_in=8'hFF -> overflow=1, readout data unchanged, overflow persists into next frame until reset.
REQ-035 After 37 strobes assert frame_start with read=1, pixel_in=8'h55 -> readout pixel 0 = 8'h55, frame_done after 99 more strobes.
REQ-036 reset at transfer 50 of readout -> out_valid=0 next cycle; new 100-pixel frame captured and read out correctly.
REQ-037 Strobe in same cycle as final transfer (out_last=1) -> strobe dropped, overflow=1, next strobe written to index 0.
